// File: rtl/cla_multiword_seq.sv
// Multi-word adder sequencer: streams WIDTH-bit operands LSB-first, 4 bits per cycle, through an external 4-bit CLA.
// Optional subtract mode via `CLA_SEQ_SUB_EN (adds a sub input; a - b computed as a + ~b + 1).
module cla_multiword_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = $clog2(NSLICE);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_multiword_seq: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_in;
    logic             c0;

    // b_q holds the operand exactly as the CLA sees it, so overflow uses the effective sign.
`ifdef CLA_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c0   = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c0   = cin;
`endif

    // NOTE: operand registers are pure datapath; they are only read in RUN after a load, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && in_ready) begin
            a_q <= a;
            b_q <= b_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        carry    <= c0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= cla_sum;
                    carry           <= cla_cout;
                    idx             <= idx + 1'b1;
                    if (idx == IDXW'(NSLICE - 1)) begin
                        cout      <= cla_cout;
                        ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: defaults first so the combinational CLA drive cannot infer a latch outside RUN.
    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (state == RUN) begin
            cla_a   = a_q[4*idx +: 4];
            cla_b   = b_q[4*idx +: 4];
            cla_cin = carry;
        end
    end

endmodule
